// File: rtl/ntsc_composite_gen.sv
// NTSC-style composite video generator: dot/line timing, sync and colour
// burst insertion, and per-CLK chroma modulation of a 6-bit palette pixel.
// Optional feature: define ODD_FRAME_SKIP_EN to drop the last dot of odd
// frames while rendering_en is high.
module ntsc_composite_gen #(
    parameter int unsigned H_TOTAL     = 341,
    parameter int unsigned V_TOTAL     = 262,
    parameter int unsigned CLK_PER_DOT = 4,
    parameter int unsigned H_ACTIVE    = 256,
    parameter int unsigned V_ACTIVE    = 240,
    parameter int unsigned HSYNC_START = 280,
    parameter int unsigned HSYNC_LEN   = 25,
    parameter int unsigned BURST_START = 309,
    parameter int unsigned BURST_LEN   = 14,
    parameter int unsigned VSYNC_START = 245,
    parameter int unsigned VSYNC_LEN   = 3,
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned BLANK_LEVEL = 46,
    parameter int unsigned LUMA_STEP   = 30,
    parameter int unsigned CHROMA_AMP  = 24,
    parameter int unsigned BURST_AMP   = 46
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [5:0]       pix_data,
    input  logic             rendering_en,
    output logic [8:0]       dot_x,
    output logic [8:0]       dot_y,
    output logic             pix_req,
    output logic             frame_start,
    output logic             odd_frame,
    output logic [OUT_W-1:0] VOUT
);

    localparam int unsigned CW = (CLK_PER_DOT > 1) ? $clog2(CLK_PER_DOT) : 1;
    localparam int unsigned LW = OUT_W + 2;

    localparam logic [CW-1:0]    CNT_LAST  = CW'(CLK_PER_DOT - 1);
    localparam logic [8:0]       X_LAST    = 9'(H_TOTAL - 1);
    localparam logic [8:0]       Y_LAST    = 9'(V_TOTAL - 1);
    localparam logic [8:0]       X_SKIP    = 9'(H_TOTAL - 2);
    localparam logic [OUT_W-1:0] LVL_BLANK = OUT_W'(BLANK_LEVEL);
    localparam logic [OUT_W-1:0] BURST_HI  = OUT_W'(BLANK_LEVEL + BURST_AMP / 2);
    localparam logic [OUT_W-1:0] BURST_LO  = OUT_W'(BLANK_LEVEL - BURST_AMP / 2);

    localparam logic signed [LW-1:0] CHR     = LW'(CHROMA_AMP / 2);
    localparam logic signed [LW-1:0] LVL_MIN = LW'(1);
    localparam logic signed [LW-1:0] LVL_MAX = LW'((1 << OUT_W) - 1);

    // True when v lies in the half-open window [start, start+len)
    function automatic logic in_win(input logic [8:0] v, input int unsigned start,
                                    input int unsigned len);
        return (32'(v) >= start) && (32'(v) < start + len);
    endfunction

    // Chroma sign: positive while (phase + hue) mod 12 falls in the first half
    function automatic logic chroma_pos(input logic [3:0] ph, input logic [3:0] hue);
        logic [4:0] s;
        s = 5'(ph) + 5'(hue);
        if (s >= 5'd12) begin
            s = s - 5'd12;
        end
        return s < 5'd6;
    endfunction

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [8:0]       x_q, x_d;
    logic [8:0]       y_q, y_d;
    logic [8:0]       y_succ;
    logic [3:0]       ph_q, ph_d;
    logic             odd_q, odd_d;
    logic             pix_req_q, pix_req_d;
    logic             fs_q, fs_d;
    logic [5:0]       pix_q, pix_d;
    logic [5:0]       disp_q, disp_d;
    logic [OUT_W-1:0] vout_q, vout_d;
    logic             tick;
    logic             skip;
    logic             skip_fetch;
    logic signed [LW-1:0] lvl;
    logic [3:0]       hue;

    assign tick = (cnt_q == CNT_LAST);

`ifdef ODD_FRAME_SKIP_EN
    // Odd frames lose their final dot when rendering is on at the skip point
    assign skip       = tick && odd_q && rendering_en && (x_q == X_SKIP) && (y_q == Y_LAST);
    assign skip_fetch = odd_q;
`else
    logic unused_rendering_en;
    assign unused_rendering_en = rendering_en;
    assign skip       = 1'b0;
    assign skip_fetch = 1'b0;
`endif

    // Dot divider, raster counters, frame parity and pixel fetch pipeline
    always_comb begin
        cnt_d     = cnt_q + CW'(1);
        x_d       = x_q;
        y_d       = y_q;
        y_succ    = '0;
        odd_d     = odd_q;
        fs_d      = 1'b0;
        pix_req_d = 1'b0;
        pix_d     = pix_q;
        disp_d    = disp_q;
        ph_d      = (ph_q >= 4'd10) ? 4'd0 : ph_q + 4'd2;

        if (pix_req_q) begin
            pix_d = pix_data;
        end

        if (tick) begin
            cnt_d  = '0;
            disp_d = pix_q;
            if (skip || (x_q == X_LAST)) begin
                x_d = '0;
                if (skip || (y_q == Y_LAST)) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + 9'd1;
                end
            end else begin
                x_d = x_q + 9'd1;
            end

            fs_d = (x_d == 9'd0) && (y_d == 9'd0);
            if (fs_d) begin
                odd_d = ~odd_q;
            end

            // Fetch during this dot the pixel shown on the dot after it
            y_succ    = (y_d == Y_LAST) ? 9'd0 : y_d + 9'd1;
            pix_req_d = ((32'(x_d) + 32'd1 < H_ACTIVE) && (32'(y_d) < V_ACTIVE))
                     || ((x_d == X_LAST) && (32'(y_succ) < V_ACTIVE))
                     || (skip_fetch && (x_d == X_SKIP) && (y_d == Y_LAST));
        end
    end

    // Output level for the upcoming CLK: sync > burst > active > blank
    always_comb begin
        hue = disp_d[3:0];
        lvl = LW'(BLANK_LEVEL) + (LW'(disp_d[5:4]) + LW'(1)) * LW'(LUMA_STEP);
        if ((hue >= 4'd1) && (hue <= 4'd12)) begin
            lvl = chroma_pos(ph_d, hue) ? lvl + CHR : lvl - CHR;
        end
        if (lvl < LVL_MIN) begin
            lvl = LVL_MIN;
        end else if (lvl > LVL_MAX) begin
            lvl = LVL_MAX;
        end

        vout_d = LVL_BLANK;
        if (in_win(x_d, HSYNC_START, HSYNC_LEN) || in_win(y_d, VSYNC_START, VSYNC_LEN)) begin
            vout_d = '0;
        end else if (in_win(x_d, BURST_START, BURST_LEN)) begin
            vout_d = chroma_pos(ph_d, 4'd8) ? BURST_HI : BURST_LO;
        end else if ((32'(x_d) < H_ACTIVE) && (32'(y_d) < V_ACTIVE) && (hue <= 4'd13)) begin
            vout_d = lvl[OUT_W-1:0];
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            ph_q      <= '0;
            odd_q     <= 1'b0;
            pix_req_q <= 1'b0;
            fs_q      <= 1'b0;
            pix_q     <= '0;
            disp_q    <= '0;
            vout_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            x_q       <= x_d;
            y_q       <= y_d;
            ph_q      <= ph_d;
            odd_q     <= odd_d;
            pix_req_q <= pix_req_d;
            fs_q      <= fs_d;
            pix_q     <= pix_d;
            disp_q    <= disp_d;
            vout_q    <= vout_d;
        end
    end

    assign dot_x       = x_q;
    assign dot_y       = y_q;
    assign pix_req     = pix_req_q;
    assign frame_start = fs_q;
    assign odd_frame   = odd_q;
    assign VOUT        = vout_q;

endmodule

// File: doc/ntsc_composite_gen.md
NTSC_COMPOSITE_GEN -- requirements
Module: ntsc_composite_gen

Interface
REQ-001 SHALL have parameter H_TOTAL, default 341: dots per line, counted 0..H_TOTAL-1.
REQ-002 SHALL have parameter V_TOTAL, default 262: lines per frame, counted 0..V_TOTAL-1.
REQ-003 SHALL have parameter CLK_PER_DOT, default 4: CLK cycles per dot, minimum 2.
REQ-004 SHALL have parameters H_ACTIVE 256, V_ACTIVE 240, HSYNC_START 280, HSYNC_LEN 25, BURST_START 309, BURST_LEN 14, VSYNC_START 245, VSYNC_LEN 3: timing windows, all in dots or lines.
REQ-005 SHALL have parameters OUT_W 8, BLANK_LEVEL 46, LUMA_STEP 30, CHROMA_AMP 24, BURST_AMP 46: output levels in DAC codes.
REQ-006 SHALL have ports: CLK in 1 system clock; RST in 1 reset; pix_data in 6 {luma[5:4], hue[3:0]}; rendering_en in 1 rendering active.
REQ-007 SHALL have ports: dot_x out 9 current dot; dot_y out 9 current line; pix_req out 1 pixel fetch strobe; frame_start out 1 frame pulse; odd_frame out 1 frame parity; VOUT out OUT_W composite DAC code.
REQ-008 SHALL use one clock, CLK; RST SHALL be synchronous and active-high.

Function
REQ-009 SHALL have a clock-enable divider cnt (0..CLK_PER_DOT-1); the dot tick SHALL be asserted when cnt==CLK_PER_DOT-1.
REQ-010 On each dot tick, dot_x SHALL increment. At H_TOTAL-1 it SHALL wrap to 0 and dot_y SHALL increment. dot_y SHALL wrap to 0 after V_TOTAL-1, and odd_frame SHALL toggle on that wrap.
REQ-011 frame_start SHALL pulse high for exactly one CLK on the tick that loads dot_x=0, dot_y=0.
REQ-012 pix_req SHALL pulse for one CLK on the dot tick when the next dot is active (x<H_ACTIVE, y<V_ACTIVE). pix_data SHALL be sampled on the following CLK and displayed for the full next dot (latency 1 dot).
REQ-013 A phase counter ph (0..11) SHALL advance by 2 mod 12 every CLK and be free-running across lines and frames.
REQ-014 Chroma sign for hue h in 1..12: positive when ((ph + h) mod 12) < 6, else negative. Hue 0 and hue 13..15 SHALL carry no chroma. Hue 14/15 SHALL additionally force luma to blank (black).
REQ-015 Active level SHALL be BLANK_LEVEL + (luma+1)*LUMA_STEP ± CHROMA_AMP/2. It SHALL be computed at OUT_W+2 bits signed and clamped to [1, 2^OUT_W-1].
REQ-016 During HSYNC window, or during VSYNC lines, VOUT SHALL be 0 (sync level), which takes priority over everything else.
REQ-017 During BURST window on non-VSYNC lines, VOUT SHALL be BLANK_LEVEL ± BURST_AMP/2, using the sign for hue 8.
REQ-018 All other non-active dots SHALL output VOUT=BLANK_LEVEL.
REQ-019 VOUT SHALL be registered, and SHALL be updated every CLK so that chroma phase changes within a dot.
REQ-020 If parameter windows overlap, the priority SHALL be sync > burst > active > blank.

Reset
REQ-021 While RST=1: cnt, dot_x, dot_y, ph = 0; odd_frame=0; pix_req=0; frame_start=0; VOUT=0; held pixel = 0.
REQ-022 Reset asserted mid-line SHALL take effect on the next CLK edge with no partial completion. After release, the first dot tick SHALL advance dot_x to 1 and SHALL NOT pulse frame_start.

Configuration
REQ-023 With ODD_FRAME_SKIP_EN defined: when odd_frame=1 and rendering_en=1 at dot (H_TOTAL-2, V_TOTAL-1), the next tick SHALL jump directly to (0,0), making that frame one dot short. rendering_en SHALL be sampled on that tick only.
REQ-024 Without ODD_FRAME_SKIP_EN, every frame SHALL be exactly H_TOTAL*V_TOTAL dots, and rendering_en SHALL be ignored.

Verification
REQ-025 Defaults, run 2 frames -> frame_start period = 341*262*4 = 357368 CLKs, and odd_frame toggles each frame.
REQ-026 ODD_FRAME_SKIP_EN, rendering_en=1 -> frame lengths alternate 357368 / 357364 CLKs. With rendering_en=0 -> all frames 357368.
REQ-027 pix_data=6'h30 (luma3, hue0) at dot (10,5) -> VOUT=166 for all 4 CLKs of dot 11. pix_data=6'h0E -> VOUT=46.
REQ-028 pix_data hue=1 luma=0, fixed -> VOUT alternates between 64 and 88 with a 6-CLK period; hue=7 -> the same values in opposite phase.
REQ-029 Line 245, dot 100 -> VOUT=0. Line 10, dot 310 -> VOUT alternates 23/69. Line 10, dot 290 -> VOUT=0.
REQ-030 Assert RST at dot (150,100) for 3 CLKs -> all outputs 0 during reset. The first frame_start then occurs after 357368 CLKs.
